// File: rtl/keccak_chi_dom_stream.sv
// Masked Keccak chi+iota (DOM) with valid/ready stream and randomness handshake.
// Ports: ClkxCI/RstxRI clock and sync reset; InValidxSI/InReadyxSO/InputxDI input
// stream; IotaRCxDI round constant per row; ZxDI/RndValidxSI/RndReadyxSO fresh
// randomness; OutValidxSO/OutReadyxSI/OutputxDO output stream; LastxSO last beat.
module keccak_chi_dom_stream #(
    parameter int SHARES    = 3,
    parameter int ROWS      = 5,
    parameter int BEATS     = 64,
    parameter int LESS_RAND = 0
) (
    input  logic                                    ClkxCI,
    input  logic                                    RstxRI,
    input  logic                                    InValidxSI,
    output logic                                    InReadyxSO,
    input  logic [SHARES*ROWS*5-1:0]                InputxDI,
    input  logic [ROWS-1:0]                         IotaRCxDI,
    input  logic [(SHARES*(SHARES-1)/2)*ROWS*5-1:0] ZxDI,
    input  logic                                    RndValidxSI,
    output logic                                    RndReadyxSO,
    output logic                                    OutValidxSO,
    input  logic                                    OutReadyxSI,
    output logic [SHARES*ROWS*5-1:0]                OutputxDO,
    output logic                                    LastxSO
);
    localparam int NPAIR = SHARES*(SHARES-1)/2;
    localparam int W     = ROWS*5;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BEATS-1);

    logic [W-1:0]  term_d [SHARES][SHARES];
    logic [W-1:0]  term_q [SHARES][SHARES];
    logic [CW-1:0] cnt_q;
    logic          valid_q;
    logic          last_q;
    logic          accept;

    // Ready depends on output-side space only, never on the input valids.
    assign InReadyxSO  = ~valid_q | OutReadyxSI;
    assign accept      = InValidxSI & RndValidxSI & InReadyxSO & ~RstxRI;
    assign RndReadyxSO = accept;
    assign OutValidxSO = valid_q;
    assign LastxSO     = last_q;

    for (genvar i = 0; i < SHARES; i++) begin : g_i
        for (genvar j = 0; j < SHARES; j++) begin : g_j
            localparam int P = (i < j) ? i + j*(j-1)/2 : j + i*(i-1)/2;
            logic [W-1:0] t;
            for (genvar r = 0; r < ROWS; r++) begin : g_r
                for (genvar x = 0; x < 5; x++) begin : g_x
                    localparam int B  = r*5 + x;
                    localparam int B1 = r*5 + (x+1)%5;
                    localparam int B2 = r*5 + (x+2)%5;
                    if (i == j) begin : g_in
                        // The last two shares drop their linear part when the
                        // share itself serves as refresh of the last pair.
                        if (LESS_RAND != 0 && i >= SHARES-2) begin : g_lr
                            assign t[B] = ~InputxDI[i*W+B1] & InputxDI[i*W+B2];
                        end else begin : g_full
                            assign t[B] = InputxDI[i*W+B]
                                        ^ (~InputxDI[i*W+B1] & InputxDI[i*W+B2]);
                        end
                    end else begin : g_cr
                        logic rf;
                        logic rc;
                        if (LESS_RAND != 0 && P == NPAIR-1) begin : g_rs
                            assign rf = InputxDI[i*W+B];
                        end else begin : g_rz
                            assign rf = ZxDI[P*W+B];
                        end
                        if (i == 0 && j == 1 && x == 0) begin : g_io
                            assign rc = IotaRCxDI[r];
                        end else begin : g_nio
                            assign rc = 1'b0;
                        end
                        assign t[B] = (InputxDI[i*W+B1] & InputxDI[j*W+B2]) ^ rf ^ rc;
                    end
                end
            end
            assign term_d[i][j] = t;
        end

        // Pure XOR tree straight off the term flops.
        logic [W-1:0] o;
        always_comb begin
            o = '0;
            for (int k = 0; k < SHARES; k++) o = o ^ term_q[i][k];
        end
        assign OutputxDO[i*W +: W] = o;
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            term_q  <= '{default: '0};
            cnt_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            if (accept) begin
                term_q <= term_d;
                last_q <= (cnt_q == CNT_LAST);
                cnt_q  <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
            if (accept)           valid_q <= 1'b1;
            else if (OutReadyxSI) valid_q <= 1'b0;
        end
    end
endmodule
